// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: command/response encodings and letter constants.
package enigma_pkg;

  localparam int unsigned LETTER_W = 5;
  localparam int unsigned NLETTERS = 26;
  localparam logic [LETTER_W-1:0] EMPTY = 5'h1F;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_DEL   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] RSP_OK        = 3'd0;
  localparam logic [2:0] RSP_BAD_ARG   = 3'd1;
  localparam logic [2:0] RSP_IN_USE    = 3'd2;
  localparam logic [2:0] RSP_FULL      = 3'd3;
  localparam logic [2:0] RSP_NOT_FOUND = 3'd4;

endpackage

// File: rtl/plugboard_cfg.sv
// Plugboard wiring table controller: validates add/delete/clear commands with a
// full sequential slot scan and commits table updates atomically.
module plugboard_cfg
  import enigma_pkg::*;
#(
  parameter int unsigned NPAIRS = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LETTER_W-1:0]   cmd_a,
  input  logic [LETTER_W-1:0]   cmd_b,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_code,
  output logic [3:0]            pair_count,
  output logic [NPAIRS*10-1:0]  tbl
);

  localparam int unsigned SLOT_W = 2 * LETTER_W;
  localparam int unsigned IDX_W  = $clog2(NPAIRS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t              state, state_n;
  logic [1:0]          op_q;
  logic [LETTER_W-1:0] a_q, b_q;
  logic [IDX_W-1:0]    idx;
  logic                in_use, found;
  logic [IDX_W-1:0]    slot_q;
  logic [2:0]          code_n;
  logic                bad_arg;
  logic [SLOT_W-1:0]   cur_slot;
  logic [LETTER_W-1:0] e0, e1;
  logic                hit_ab, hit_a, is_empty;

  // Slot under the scan pointer and its match flags
  always_comb begin
    cur_slot = tbl[idx*SLOT_W +: SLOT_W];
    e0       = cur_slot[LETTER_W-1:0];
    e1       = cur_slot[SLOT_W-1:LETTER_W];
    hit_ab   = (e0 == a_q) || (e0 == b_q) || (e1 == a_q) || (e1 == b_q);
    hit_a    = (e0 == a_q) || (e1 == a_q);
    is_empty = (e0 == EMPTY) && (e1 == EMPTY);
  end

  always_comb begin
    if (op_q == OP_ADD)
      bad_arg = (a_q > LETTER_W'(NLETTERS-1)) || (b_q > LETTER_W'(NLETTERS-1)) || (a_q == b_q);
    else
      bad_arg = (a_q > LETTER_W'(NLETTERS-1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state and the response code latched on entry to RESP
  always_comb begin
    state_n = state;
    code_n  = rsp_code;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ADD || cmd_op == OP_DEL) begin
            state_n = S_CHECK;
          end else begin
            state_n = S_RESP;
            code_n  = RSP_OK;
          end
        end
      end
      S_CHECK: begin
        if (bad_arg) begin
          state_n = S_RESP;
          code_n  = RSP_BAD_ARG;
        end else begin
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx == IDX_W'(NPAIRS-1)) state_n = S_COMMIT;
      end
      S_COMMIT: begin
        state_n = S_RESP;
        if (op_q == OP_ADD) begin
          if (in_use)      code_n = RSP_IN_USE;
          else if (!found) code_n = RSP_FULL;
          else             code_n = RSP_OK;
        end else begin
          code_n = found ? RSP_OK : RSP_NOT_FOUND;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand latch, scan bookkeeping, table bank and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      in_use     <= 1'b0;
      found      <= 1'b0;
      slot_q     <= '0;
      tbl        <= '1;
      pair_count <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_code   <= RSP_OK;
      cmd_ready  <= 1'b1;
    end else begin
      cmd_ready <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RESP);
      if (state_n == S_RESP) rsp_code <= code_n;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            if (cmd_op == OP_CLEAR) begin
              tbl        <= '1;
              pair_count <= 4'd0;
            end
          end
        end
        S_CHECK: begin
          idx    <= '0;
          in_use <= 1'b0;
          found  <= 1'b0;
          slot_q <= '0;
        end
        S_SCAN: begin
          idx <= idx + IDX_W'(1);
          if (op_q == OP_ADD) begin
            if (hit_ab) in_use <= 1'b1;
            if (is_empty && !found) begin
              found  <= 1'b1;
              slot_q <= idx;
            end
          end else if (hit_a) begin
            found  <= 1'b1;
            slot_q <= idx;
          end
        end
        S_COMMIT: begin
          if (code_n == RSP_OK) begin
            if (op_q == OP_ADD) begin
              tbl[slot_q*SLOT_W +: SLOT_W] <= {b_q, a_q};
              pair_count <= pair_count + 4'd1;
            end else begin
              tbl[slot_q*SLOT_W +: SLOT_W] <= {EMPTY, EMPTY};
              pair_count <= pair_count - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plugboard_cfg.sv
// Directed, table-driven bench for plugboard_cfg with a small wiring-table model.
module tb_plugboard_cfg;
  import enigma_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [4:0]   cmd_a = 5'd0;
  logic [4:0]   cmd_b = 5'd0;
  logic         rsp_valid;
  logic [2:0]   rsp_code;
  logic [3:0]   pair_count;
  logic [129:0] tbl;

  int n_cmp = 0;
  int n_bad = 0;

  plugboard_cfg #(.NPAIRS(13)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
    .rsp_code(rsp_code), .pair_count(pair_count), .tbl(tbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] code;
    int         lat;
    int         cnt;
  } vec_t;

  vec_t         v[$];
  logic [129:0] m_tbl;

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected-table update for a command known to succeed
  task automatic model_apply(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    bit done = 0;
    if (op == OP_CLEAR) m_tbl = '1;
    for (int k = 0; k < 13; k++) begin
      if (!done && op == OP_ADD && m_tbl[k*10 +: 10] == 10'h3FF) begin
        m_tbl[k*10 +: 10] = {b, a};
        done = 1;
      end
      if (!done && op == OP_DEL && (m_tbl[k*10 +: 5] == a || m_tbl[k*10+5 +: 5] == a)) begin
        m_tbl[k*10 +: 10] = 10'h3FF;
        done = 1;
      end
    end
  endtask

  // Issue one command; returns the response code and latency (0 on timeout)
  task automatic run(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                     output logic [2:0] code, output int lat, output bit stable);
    logic [129:0] pre;
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    pre = tbl;
    stable = 1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = 5'($urandom); cmd_b = 5'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (tbl !== pre) stable = 0;
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = 0;
    code = rsp_code;
  endtask

  task automatic apply(input vec_t t, input string name);
    logic [2:0] code;
    int lat;
    bit stable;
    run(t.op, t.a, t.b, code, lat, stable);
    if (t.code == RSP_OK) model_apply(t.op, t.a, t.b);
    chk({name, " latency"}, 130'(lat), 130'(t.lat));
    chk({name, " code"}, 130'(code), 130'(t.code));
    chk({name, " count"}, 130'(pair_count), 130'(t.cnt));
    chk({name, " tbl"}, tbl, m_tbl);
    chk({name, " tbl stable"}, 130'(stable), 130'(1));
  endtask

  initial begin
    logic [2:0] code;
    int lat;
    bit stable;
    m_tbl = '1;

    #12;
    chk("reset tbl", tbl, {130{1'b1}});
    chk("reset count", 130'(pair_count), 130'(0));
    chk("reset rsp_valid", 130'(rsp_valid), 130'(0));
    chk("reset rsp_code", 130'(rsp_code), 130'(0));
    chk("reset cmd_ready", 130'(cmd_ready), 130'(1));
    @(negedge clk); reset_n = 1'b1;

    v.push_back('{OP_CLEAR, 5'd0,  5'd0, RSP_OK,        1,  0});
    v.push_back('{OP_ADD,   5'd0,  5'd4, RSP_OK,        16, 1});
    v.push_back('{OP_ADD,   5'd4,  5'd7, RSP_IN_USE,    16, 1});
    v.push_back('{OP_ADD,   5'd9,  5'd9, RSP_BAD_ARG,   2,  1});
    v.push_back('{OP_ADD,   5'd26, 5'd1, RSP_BAD_ARG,   2,  1});
    v.push_back('{OP_NOP,   5'd3,  5'd5, RSP_OK,        1,  1});
    v.push_back('{OP_DEL,   5'd4,  5'd0, RSP_OK,        16, 0});
    v.push_back('{OP_DEL,   5'd10, 5'd0, RSP_NOT_FOUND, 16, 0});
    v.push_back('{OP_DEL,   5'd30, 5'd0, RSP_BAD_ARG,   2,  0});
    for (int k = 0; k < 13; k++)
      v.push_back('{OP_ADD, 5'(2*k), 5'(2*k+1), RSP_OK, 16, k+1});
    v.push_back('{OP_ADD,   5'd25, 5'd2, RSP_IN_USE,    16, 13});
    v.push_back('{OP_DEL,   5'd3,  5'd0, RSP_OK,        16, 12});
    v.push_back('{OP_ADD,   5'd2,  5'd3, RSP_OK,        16, 13});
    v.push_back('{OP_CLEAR, 5'd0,  5'd0, RSP_OK,        1,  0});

    for (int i = 0; i < v.size(); i++) begin
      apply(v[i], $sformatf("vec%0d", i));
      if (i == 1) chk("slot0 after add 0,4", 130'(tbl[9:0]), 130'({5'd4, 5'd0}));
      if (i == 23) chk("slot1 after del 3", 130'(tbl[19:10]), 130'(10'h3FF));
      if (i == 24) chk("slot1 after add 2,3", 130'(tbl[19:10]), 130'({5'd3, 5'd2}));
    end

    // Reset during the scan of an ADD abandons it without a response
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 5'd5; cmd_b = 5'd6;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    chk("midreset rsp_valid", 130'(rsp_valid), 130'(0));
    chk("midreset tbl", tbl, {130{1'b1}});
    chk("midreset cmd_ready", 130'(cmd_ready), 130'(1));
    chk("midreset count", 130'(pair_count), 130'(0));
    repeat (20) begin
      @(posedge clk); #1;
      chk("midreset no rsp", 130'(rsp_valid), 130'(0));
    end
    @(negedge clk); reset_n = 1'b1;
    m_tbl = '1;

    run(OP_ADD, 5'd5, 5'd6, code, lat, stable);
    chk("post-reset add latency", 130'(lat), 130'(16));
    chk("post-reset add code", 130'(code), 130'(RSP_OK));
    chk("post-reset add slot0", 130'(tbl[9:0]), 130'({5'd6, 5'd5}));
    chk("post-reset add count", 130'(pair_count), 130'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
